// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that time-shares one combinational ALU among NREQ requesters.
// Operands are registered into the ALU, held ALU_LAT cycles, then result and flags are returned.
module alu_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 6,
  parameter int unsigned ALU_LAT = 1,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [2*NREQ-1:0]   req_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [1:0]          alu_op,
  input  logic [7:0]          alu_y,
  input  logic [4:0]          alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_y,
  output logic [4:0]          rsp_flags,
  output logic                busy,
  output logic [15:0]         op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [3:0]     wait_q, wait_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]     alu_op_q, alu_op_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     rsp_y_q, rsp_y_d;
  logic [4:0]     rsp_flags_q, rsp_flags_d;
  logic [15:0]    op_count_q, op_count_d;

  logic [W-1:0]   a_arr  [NREQ];
  logic [W-1:0]   b_arr  [NREQ];
  logic [1:0]     op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*W +: W];
    assign b_arr[i]  = req_b[i*W +: W];
    assign op_arr[i] = req_op[2*i +: 2];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  always_comb begin
    logic [IDW:0] sum;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    wait_d      = wait_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          alu_a_d            = a_arr[gnt_idx];
          alu_b_d            = b_arr[gnt_idx];
          alu_op_d           = op_arr[gnt_idx];
          gnt_d              = gnt_idx;
          wait_d             = 4'(ALU_LAT - 1);
          state_d            = StExec;
        end
      end
      StExec: begin
        if (wait_q == 4'd0) begin
          rsp_y_d     = alu_y;
          rsp_flags_d = alu_flags;
          rsp_id_d    = gnt_q;
          state_d     = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          op_count_d = op_count_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      wait_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      wait_q      <= wait_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign op_count  = op_count_q;
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus a randomized run against a
// transaction-level model (round-robin pick, fixed latency, response timestamps).
module tb_alu_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Operand sources shared by both DUT instances
  logic [W-1:0] pa [NREQ];
  logic [W-1:0] pb [NREQ];
  logic [1:0]   pop[NREQ];
  logic [NREQ*W-1:0] req_a, req_b;
  logic [2*NREQ-1:0] req_op;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
      req_op[2*i +: 2] = pop[i];
    end
  end

  // Reference ALU: returns {overflow, greater, less, is_eq, parity, y}
  function automatic logic [12:0] alu_fn(input logic [5:0] a, input logic [5:0] b,
                                         input logic [1:0] op);
    logic [7:0] y;
    logic ov;
    ov = 1'b0;
    case (op)
      2'd0: y = {2'b0, a} - {2'b0, b};
      2'd1: begin y = {2'b0, a} + {2'b0, b}; ov = y[6]; end
      2'd2: y = {2'b0, a & b};
      default: y = {2'b0, a ^ b};
    endcase
    return {ov, a > b, a < b, a == b, ^y, y};
  endfunction

  // Instance with ALU_LAT=1
  logic [NREQ-1:0] req_valid, req_ready;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_y;
  logic [4:0] alu_flags;
  logic rsp_valid, rsp_ready, busy;
  logic [1:0] rsp_id;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;
  logic [15:0] op_count;

  assign {alu_flags, alu_y} = alu_fn(alu_a, alu_b, alu_op);

  alu_rr_scheduler #(.NREQ(NREQ), .W(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .busy(busy), .op_count(op_count)
  );

  // Instance with ALU_LAT=4; its ALU output can be perturbed through glitch4
  logic [NREQ-1:0] req_valid4, req_ready4;
  logic [W-1:0] alu_a4, alu_b4;
  logic [1:0] alu_op4;
  logic [7:0] alu_y4, glitch4;
  logic [4:0] alu_flags4;
  logic rsp_valid4, rsp_ready4, busy4;
  logic [1:0] rsp_id4;
  logic [7:0] rsp_y4;
  logic [4:0] rsp_flags4;
  logic [15:0] op_count4;

  assign {alu_flags4, alu_y4} = alu_fn(alu_a4, alu_b4, alu_op4) ^ {5'b0, glitch4};

  alu_rr_scheduler #(.NREQ(NREQ), .W(W), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_y(alu_y4), .alu_flags(alu_flags4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_y(rsp_y4),
    .rsp_flags(rsp_flags4), .busy(busy4), .op_count(op_count4)
  );

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_valid4 = '0;
    rsp_ready4 = 1'b0;
    glitch4 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b busy=%b exp all 0", req_ready, rsp_valid, busy);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 14'b0) begin
      errors++;
      $display("FAIL reset_alu got a=%0d b=%0d op=%0d exp 0", alu_a, alu_b, alu_op);
    end
    checks++;
    if ({rsp_id, rsp_y, rsp_flags, op_count} !== 31'b0) begin
      errors++;
      $display("FAIL reset_rsp got id=%0d y=%0d flags=%b cnt=%0d exp 0",
               rsp_id, rsp_y, rsp_flags, op_count);
    end
    checks++;
    if ({req_ready4, rsp_valid4, busy4, op_count4} !== 22'b0) begin
      errors++;
      $display("FAIL reset_lat4 got ready=%b valid=%b busy=%b cnt=%0d exp 0",
               req_ready4, rsp_valid4, busy4, op_count4);
    end
  endtask

  task automatic test_single();
    do_reset();
    pa[2] = 6'd5; pb[2] = 6'd3; pop[2] = 2'd1;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_exec got ready=%b valid=%b busy=%b exp 0000/0/1", req_ready, rsp_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 8'd8 || rsp_flags !== 5'b01001) begin
      errors++;
      $display("FAIL single_rsp got valid=%b id=%0d y=%0d flags=%b exp 1/2/8/01001",
               rsp_valid, rsp_id, rsp_y, rsp_flags);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
      errors++; $display("FAIL single_done got valid=%b cnt=%0d exp 0/1", rsp_valid, op_count);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = 6'(i + 10); pb[i] = 6'(i + 1); pop[i] = 2'(i);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      exp = (cyc % 3 == 0) ? (4'b0001 << ((cyc / 3) % 4)) : 4'b0000;
      checks++;
      if (req_ready !== exp) begin
        errors++; $display("FAIL rr_grant cyc=%0d got %b exp %b", cyc, req_ready, exp);
      end
      if (cyc % 3 == 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((cyc / 3) % 4)) begin
          errors++;
          $display("FAIL rr_rsp cyc=%0d got valid=%b id=%0d exp 1/%0d", cyc, rsp_valid, rsp_id,
                   (cyc / 3) % 4);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [12:0] e0, e1;
    do_reset();
    pa[0] = 6'($urandom); pb[0] = 6'($urandom); pop[0] = 2'($urandom);
    pa[1] = 6'($urandom); pb[1] = 6'($urandom); pop[1] = 2'($urandom);
    e0 = alu_fn(pa[0], pb[0], pop[0]);
    e1 = alu_fn(pa[1], pb[1], pop[1]);
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_first got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_flags, rsp_y} !== e0 ||
          req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b id=%0d r=%h rdy=%b exp 1/0/%h/0000",
                 k, rsp_valid, rsp_id, {rsp_flags, rsp_y}, req_ready, e0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || op_count !== 16'd1) begin
      errors++; $display("FAIL bp_next got rdy=%b cnt=%0d exp 0010/1", req_ready, op_count);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_flags, rsp_y} !== e1) begin
      errors++;
      $display("FAIL bp_second got v=%b id=%0d r=%h exp 1/1/%h", rsp_valid, rsp_id,
               {rsp_flags, rsp_y}, e1);
    end
  endtask

  task automatic test_lat4();
    logic [12:0] e;
    do_reset();
    pa[1] = 6'($urandom); pb[1] = 6'($urandom); pop[1] = 2'($urandom);
    e = alu_fn(pa[1], pb[1], pop[1]) ^ 13'h03C;
    req_valid4 = 4'b0010;
    #1;
    checks++;
    if (req_ready4 !== 4'b0010) begin
      errors++; $display("FAIL lat4_ready got %b exp 0010", req_ready4);
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      req_valid4 = '0;
      if (j == 3) glitch4 = 8'hA5;
      if (j == 4) glitch4 = 8'h3C;
      #1;
      checks++;
      if (alu_a4 !== pa[1] || alu_b4 !== pb[1] || alu_op4 !== pop[1] || rsp_valid4 !== 1'b0 ||
          busy4 !== 1'b1) begin
        errors++;
        $display("FAIL lat4_hold T+%0d got a=%0d b=%0d op=%0d v=%b busy=%b exp %0d/%0d/%0d/0/1",
                 j, alu_a4, alu_b4, alu_op4, rsp_valid4, busy4, pa[1], pb[1], pop[1]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid4 !== 1'b1 || rsp_id4 !== 2'd1 || {rsp_flags4, rsp_y4} !== e) begin
      errors++;
      $display("FAIL lat4_capture got v=%b id=%0d r=%h exp 1/1/%h", rsp_valid4, rsp_id4,
               {rsp_flags4, rsp_y4}, e);
    end
    rsp_ready4 = 1'b1;
    @(negedge clk);
    rsp_ready4 = 1'b0;
    glitch4 = '0;
    #1;
    checks++;
    if (op_count4 !== 16'd1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL lat4_done got cnt=%0d busy=%b exp 1/0", op_count4, busy4);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    pa[2] = 6'd7; pb[2] = 6'd9; pop[2] = 2'd1;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, alu_a, alu_b, alu_op} !== 20'b0 ||
        {rsp_id, rsp_y, rsp_flags, op_count} !== 31'b0) begin
      errors++;
      $display("FAIL rst_exec_outputs got rdy=%b v=%b busy=%b a=%0d y=%0d cnt=%0d exp 0",
               req_ready, rsp_valid, busy, alu_a, rsp_y, op_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
        errors++; $display("FAIL rst_exec_quiet k=%0d got v=%b cnt=%0d exp 0/0", k, rsp_valid, op_count);
      end
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rst_exec_ptr got %b exp 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    dut.op_count_q = 16'hFFFF;
    pa[0] = 6'd1; pb[0] = 6'd2; pop[0] = 2'd1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || op_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got v=%b cnt=%h exp 1/ffff", rsp_valid, op_count);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (op_count !== 16'h0000 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_cnt got cnt=%h v=%b exp 0000/0", op_count, rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] pend, exp_ready;
    logic [12:0] mexp;
    logic mbusy, found, exp_rv;
    int ptr, cnt, mrsp, mg, g, idx;
    pend = '0; mbusy = 1'b0; ptr = 0; cnt = 0; mrsp = 0; mg = 0; mexp = '0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 6'($urandom); pb[i] = 6'($urandom); pop[i] = 2'($urandom);
        end
      end
      req_valid = pend;
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      found = 1'b0; g = 0; exp_ready = '0;
      if (!mbusy) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (!found && pend[idx]) begin found = 1'b1; g = idx; end
        end
      end
      if (found) exp_ready[g] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, req_ready, exp_ready);
      end
      exp_rv = mbusy && (cyc >= mrsp);
      checks++;
      if (rsp_valid !== exp_rv || busy !== mbusy) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got v=%b busy=%b exp %b/%b", cyc, rsp_valid, busy,
                 exp_rv, mbusy);
      end
      if (exp_rv) begin
        checks++;
        if ({rsp_id, rsp_flags, rsp_y} !== {2'(mg), mexp}) begin
          errors++;
          $display("FAIL rand_rsp cyc=%0d got id=%0d r=%h exp %0d/%h", cyc, rsp_id,
                   {rsp_flags, rsp_y}, mg, mexp);
        end
      end
      checks++;
      if (op_count !== 16'(cnt)) begin
        errors++; $display("FAIL rand_count cyc=%0d got %0d exp %0d", cyc, op_count, cnt);
      end
      if (exp_rv && rsp_ready) begin
        mbusy = 1'b0;
        ptr = (mg + 1) % NREQ;
        cnt++;
      end
      if (found) begin
        mbusy = 1'b1;
        mrsp = cyc + 2;
        mg = g;
        mexp = alu_fn(pa[g], pb[g], pop[g]);
        pend[g] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0;
    req_valid4 = '0; rsp_ready4 = 1'b0; glitch4 = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lat4();
    test_reset_exec();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
